zero_count_sequencer: RTL and testbench



---
 rtl/zcs_pkg.sv | 13 +
 rtl/byte_zero_count.sv | 18 +
 rtl/zero_count_sequencer.sv | 93 +++++++++
 tb/tb_zero_count_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/zcs_pkg.sv
// rtl/zcs_pkg.sv - shared constants and state encoding for the zero-count sequencer
package zcs_pkg;

    localparam int BYTE_W     = 8;
    localparam int BYTE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_zero_count.sv
// rtl/byte_zero_count.sv - combinational count of zero bits in one byte
module byte_zero_count
    import zcs_pkg::*;
(
    input  logic [BYTE_W-1:0]     data_i,
    output logic [BYTE_CNT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            if (!data_i[i]) begin
                count_o = count_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/zero_count_sequencer.sv
// rtl/zero_count_sequencer.sv - counts zero bits of a word one byte per cycle, LSB byte first
module zero_count_sequencer
    import zcs_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int CW     = $clog2(8 * NBYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         out_count,
    output logic                  busy
);

    localparam int            IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t                  state_q;
    logic [8*NBYTES-1:0]     shift_q;
    logic [IW-1:0]           idx_q;
    logic [CW-1:0]           acc_q;
    logic [CW-1:0]           acc_d;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic [BYTE_CNT_W-1:0]   byte_cnt;

    byte_zero_count u_byte_zero_count (
        .data_i  (shift_q[BYTE_W-1:0]),
        .count_o (byte_cnt)
    );

    assign acc_d = acc_q + CW'(byte_cnt);

    // The accumulator doubles as the result register; it is only cleared on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        shift_q    <= in_data;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    shift_q <= shift_q >> BYTE_W;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = acc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_zero_count_sequencer.sv
// tb/tb_zero_count_sequencer.sv - self-checking bench for zero_count_sequencer (NBYTES=4 and NBYTES=1)
module tb_zero_count_sequencer;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  out_count;
    logic        busy;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [7:0]  in_data1 = '0;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic [3:0]  out_count1;
    logic        busy1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        int          stall;
        logic [5:0]  exp;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    zero_count_sequencer #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
    );

    zero_count_sequencer #(.NBYTES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_count (out_count1),
        .busy      (busy1)
    );

    function automatic int model_zeros(input logic [31:0] w);
        return 32 - $countones(w);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input int stall, input logic [5:0] exp,
                             input string name);
        int n;
        logic stable;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(NB));
        chk({name, "_count"}, 32'(out_count), 32'(exp));
        chk({name, "_busy_ready"}, {30'd0, busy, in_ready}, 32'd2);
        if (stall > 0) begin
            stable = 1'b1;
            for (int s = 1; s < stall; s++) begin
                @(negedge clk);
                if (!out_valid || out_count != exp || in_ready) stable = 1'b0;
            end
            chk({name, "_stall_stable"}, 32'(stable), 32'd1);
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({name, "_after_consume"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
        chk({name, "_count_held"}, 32'(out_count), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  res[$];
        logic        drop;
        logic        seen;
        logic [31:0] wa;
        logic [31:0] wb;
        logic [31:0] r;
        int          st;

        vecs[0] = '{32'hFFFF_FFFF, 0, 6'd0};
        vecs[1] = '{32'h0000_0000, 0, 6'd32};
        vecs[2] = '{32'h0F0F_00FF, 0, 6'd16};
        vecs[3] = '{32'h0000_00FF, 5, 6'd24};
        vecs[4] = '{32'h1234_5678, 0, 6'd19};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
        chk("reset_count", 32'(out_count), 32'd0);
        chk("reset_state_nb1", {28'd0, in_ready1, out_valid1, busy1, 1'b0}, 32'h8);

        for (int i = 0; i < 5; i++) begin
            send_word(vecs[i].data, vecs[i].stall, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // in_valid held across RUN/DONE: second word must wait for IDLE
        wa = 32'hF0F0_1234;
        wb = 32'h0001_FFFE;
        out_ready = 1'b1;
        in_data   = wa;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = wb;
        drop = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (drop) in_valid = 1'b0;
            drop = 1'b0;
            if (out_valid) res.push_back(out_count);
            if (in_valid && in_ready) drop = 1'b1;
        end
        chk("hold_num_results", 32'(res.size()), 32'd2);
        if (res.size() == 2) begin
            chk("hold_first", 32'(res[0]), 32'(model_zeros(wa)));
            chk("hold_second", 32'(res[1]), 32'(model_zeros(wb)));
        end
        in_valid = 1'b0;

        // reset in the middle of RUN discards the partial result
        in_data  = 32'hFFFF_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_reset_state", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
        chk("midrun_reset_count", 32'(out_count), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrun_no_pulse", 32'(seen), 32'd0);
        send_word(32'h1234_5678, 0, 6'd19, "post_reset");

        for (int i = 0; i < 25; i++) begin
            r  = $urandom;
            st = $urandom_range(0, 3);
            send_word(r, st, 6'(model_zeros(r)), $sformatf("rand%0d", i));
        end

        // single-byte build: RUN lasts one cycle
        in_data1   = 8'hA5;
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        in_data1  = 8'h00;
        chk("nb1_not_yet_valid", 32'(out_valid1), 32'd0);
        @(negedge clk);
        chk("nb1_valid", 32'(out_valid1), 32'd1);
        chk("nb1_count", 32'(out_count1), 32'd4);
        @(negedge clk);
        chk("nb1_after_consume", {30'd0, out_valid1, in_ready1}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
